// File: rtl/estagio_wb.sv
// -----------------------------------------------------------------------------
// estagio_wb : writeback stage feeding the 32x32 register bank.
//
// Accepts retired instructions from MEM over a valid/ready handshake. ALU
// results are written one cycle after acceptance; loads park in WAIT_LOAD
// until the data-memory response arrives, then the selected byte/halfword is
// sign- or zero-extended and written. A combinational hazard flag tells decode
// when a source register would read stale bank contents.
//
// Optional feature macro: WB_TIMEOUT_EN
//   defined   : WAIT_LOAD aborts after TIMEOUT_CYCLES cycles without a
//               response, with no write, and sets the sticky err flag.
//   undefined : WAIT_LOAD waits indefinitely, err is tied to 0.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  MEM-stage handshake (in_ready combinational, IDLE only)
//   in_reg_write       instruction writes rd
//   in_is_load         instruction is a load
//   in_rd              destination register
//   in_funct3          load type (LB/LH/LW/LBU/LHU)
//   in_byte_off        address[1:0] of the load
//   in_alu_result      result for non-loads
//   mem_rvalid         single-cycle load response strobe
//   mem_rdata          aligned 32-bit word from data memory
//   write_enable       bank write strobe (registered, 1-cycle pulse)
//   write              bank write address (registered)
//   data               bank write data (registered)
//   q_rs1, q_rs2       decode source-register queries
//   hazard             combinational stall request for decode
//   err                sticky load-timeout flag
// -----------------------------------------------------------------------------
module estagio_wb #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_reg_write,
   input  logic        in_is_load,
   input  logic [4:0]  in_rd,
   input  logic [2:0]  in_funct3,
   input  logic [1:0]  in_byte_off,
   input  logic [31:0] in_alu_result,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        write_enable,
   output logic [4:0]  write,
   output logic [31:0] data,
   input  logic [4:0]  q_rs1,
   input  logic [4:0]  q_rs2,
   output logic        hazard,
   output logic        err
);

   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 32;

   // Reject a zero timeout at elaboration
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("estagio_wb: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } state_t;

   state_t              state, state_nx;

   // Pending load bookkeeping
   logic [REG_W-1:0]    p_rd, p_rd_nx;
   logic                p_rw, p_rw_nx;
   logic [2:0]          p_f3, p_f3_nx;
   logic [1:0]          p_off, p_off_nx;

   // Registered bank interface
   logic                we_q, we_nx;
   logic [REG_W-1:0]    wr_q, wr_nx;
   logic [DATA_W-1:0]   data_q, data_nx;

`ifdef WB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic                err_q, err_nx;
`endif

   // Byte/halfword select and extension of the returned word
   function automatic logic [DATA_W-1:0] extend_load(input logic [2:0]        f3,
                                                      input logic [1:0]        off,
                                                      input logic [DATA_W-1:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> {off, 3'b000});
      h = 16'(word >> {off[1], 4'b0000});
      case (f3)
         3'b000:  extend_load = {{24{b[7]}}, b};
         3'b100:  extend_load = {24'b0, b};
         3'b001:  extend_load = {{16{h[15]}}, h};
         3'b101:  extend_load = {16'b0, h};
         default: extend_load = word;
      endcase
   endfunction

   // A query conflicts with the parked load or with the write landing this cycle
   function automatic logic query_hit(input logic [REG_W-1:0] q);
      logic load_hit;
      logic write_hit;
      load_hit  = (state == WAIT_LOAD) && p_rw && (q == p_rd);
      write_hit = we_q && (q == wr_q);
      query_hit = (q != '0) && (load_hit || write_hit);
   endfunction

   assign in_ready     = (state == IDLE);
   assign hazard       = query_hit(q_rs1) || query_hit(q_rs2);
   assign write_enable = we_q;
   assign write        = wr_q;
   assign data         = data_q;

`ifdef WB_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         p_rd   <= '0;
         p_rw   <= 1'b0;
         p_f3   <= '0;
         p_off  <= '0;
         we_q   <= 1'b0;
         wr_q   <= '0;
         data_q <= '0;
`ifdef WB_TIMEOUT_EN
         cnt    <= '0;
         err_q  <= 1'b0;
`endif
      end else begin
         state  <= state_nx;
         p_rd   <= p_rd_nx;
         p_rw   <= p_rw_nx;
         p_f3   <= p_f3_nx;
         p_off  <= p_off_nx;
         we_q   <= we_nx;
         wr_q   <= wr_nx;
         data_q <= data_nx;
`ifdef WB_TIMEOUT_EN
         cnt    <= cnt_nx;
         err_q  <= err_nx;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nx = state;
      p_rd_nx  = p_rd;
      p_rw_nx  = p_rw;
      p_f3_nx  = p_f3;
      p_off_nx = p_off;
      we_nx    = 1'b0;
      wr_nx    = wr_q;
      data_nx  = data_q;
`ifdef WB_TIMEOUT_EN
      cnt_nx   = cnt;
      err_nx   = err_q;
`endif

      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               if (in_is_load) begin
                  p_rd_nx  = in_rd;
                  p_rw_nx  = in_reg_write;
                  p_f3_nx  = in_funct3;
                  p_off_nx = in_byte_off;
                  state_nx = WAIT_LOAD;
`ifdef WB_TIMEOUT_EN
                  cnt_nx   = '0;
`endif
               end else if (in_reg_write && (in_rd != '0)) begin
                  we_nx   = 1'b1;
                  wr_nx   = in_rd;
                  data_nx = in_alu_result;
               end
            end
         end

         WAIT_LOAD: begin
            // A response in the limit cycle still wins over the abort
            if (mem_rvalid) begin
               state_nx = IDLE;
               if (p_rw && (p_rd != '0)) begin
                  we_nx   = 1'b1;
                  wr_nx   = p_rd;
                  data_nx = extend_load(p_f3, p_off, mem_rdata);
               end
            end
`ifdef WB_TIMEOUT_EN
            else if (cnt == CNT_LAST) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
`endif
         end
      endcase
   end

endmodule

// File: tb/tb_estagio_wb.sv
// -----------------------------------------------------------------------------
// tb_estagio_wb : self-checking bench for estagio_wb.
// A transaction-level model (pending load, expected bank write, sticky error)
// predicts in_ready, hazard and the registered bank outputs every cycle.
// Honours WB_TIMEOUT_EN with TIMEOUT_CYCLES = 4.
// -----------------------------------------------------------------------------
module tb_estagio_wb;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_reg_write;
   logic        in_is_load;
   logic [4:0]  in_rd;
   logic [2:0]  in_funct3;
   logic [1:0]  in_byte_off;
   logic [31:0] in_alu_result;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        write_enable;
   logic [4:0]  write;
   logic [31:0] data;
   logic [4:0]  q_rs1;
   logic [4:0]  q_rs2;
   logic        hazard;
   logic        err;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit          m_we;
   logic [4:0]  m_wr;
   logic [31:0] m_data;
   bit          m_busy;
   logic [4:0]  m_prd;
   bit          m_prw;
   int          m_pf3;
   int          m_poff;
   int          m_cnt;
   bit          m_err;

   estagio_wb #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_reg_write (in_reg_write),
      .in_is_load   (in_is_load),
      .in_rd        (in_rd),
      .in_funct3    (in_funct3),
      .in_byte_off  (in_byte_off),
      .in_alu_result(in_alu_result),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .write_enable (write_enable),
      .write        (write),
      .data         (data),
      .q_rs1        (q_rs1),
      .q_rs2        (q_rs2),
      .hazard       (hazard),
      .err          (err)
   );

   always #5 clk = ~clk;

   // Load result from plain arithmetic on the returned word
   function automatic logic [31:0] ref_load(input int f3, input int off, input logic [31:0] w);
      int unsigned b;
      int unsigned h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         0:       return (b >= 128) ? (b + 32'hFFFFFF00) : b;
         4:       return b;
         1:       return (h >= 32768) ? (h + 32'hFFFF0000) : h;
         5:       return h;
         default: return w;
      endcase
   endfunction

   function automatic bit exp_hit(input logic [4:0] q);
      return (q != 0) && ((m_busy && m_prw && q == m_prd) || (m_we && q == m_wr));
   endfunction

   task automatic model_reset();
      m_we = 0; m_wr = 0; m_data = 0; m_busy = 0; m_prd = 0; m_prw = 0;
      m_pf3 = 0; m_poff = 0; m_cnt = 0; m_err = 0;
   endtask

   task automatic clear_inputs();
      in_valid = 0; in_reg_write = 0; in_is_load = 0; in_rd = 0; in_funct3 = 0;
      in_byte_off = 0; in_alu_result = 0; mem_rvalid = 0; mem_rdata = 0;
      q_rs1 = 0; q_rs2 = 0;
   endtask

   // One clock: inputs already driven by the caller just after a rising edge
   task automatic cycle(input string name);
      bit eh;
      bit nwe;
      #1;
      checks++;
      if (in_ready !== !m_busy) begin
         errors++;
         $display("FAIL %s in_ready got %b exp %b", name, in_ready, !m_busy);
      end
      eh = exp_hit(q_rs1) || exp_hit(q_rs2);
      checks++;
      if (hazard !== eh) begin
         errors++;
         $display("FAIL %s hazard got %b exp %b (q1=%0d q2=%0d)", name, hazard, eh, q_rs1, q_rs2);
      end
      nwe = 0;
      if (!m_busy) begin
         if (in_valid) begin
            if (in_is_load) begin
               m_busy = 1; m_prd = in_rd; m_prw = in_reg_write;
               m_pf3 = int'(in_funct3); m_poff = int'(in_byte_off); m_cnt = 0;
            end else if (in_reg_write && in_rd != 0) begin
               nwe = 1; m_wr = in_rd; m_data = in_alu_result;
            end
         end
      end else if (mem_rvalid) begin
         m_busy = 0;
         if (m_prw && m_prd != 0) begin
            nwe = 1; m_wr = m_prd; m_data = ref_load(m_pf3, m_poff, mem_rdata);
         end
      end else begin
`ifdef WB_TIMEOUT_EN
         m_cnt++;
         if (m_cnt == TO) begin
            m_busy = 0;
            m_err  = 1;
         end
`endif
      end
      m_we = nwe;
      @(posedge clk);
      #1;
      checks++;
      if (write_enable !== m_we) begin
         errors++;
         $display("FAIL %s write_enable got %b exp %b", name, write_enable, m_we);
      end
      if (m_we) begin
         checks++;
         if (write !== m_wr || data !== m_data) begin
            errors++;
            $display("FAIL %s write/data got %0d/%h exp %0d/%h", name, write, data, m_wr, m_data);
         end
      end
      checks++;
      if (err !== m_err) begin
         errors++;
         $display("FAIL %s err got %b exp %b", name, err, m_err);
      end
      in_valid   = 0;
      mem_rvalid = 0;
   endtask

   task automatic issue_alu(input logic [4:0] rd, input logic [31:0] val, input bit rw, input string name);
      in_valid = 1; in_is_load = 0; in_reg_write = rw; in_rd = rd; in_alu_result = val;
      cycle(name);
   endtask

   task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off, input string name);
      in_valid = 1; in_is_load = 1; in_reg_write = 1; in_rd = rd; in_funct3 = f3; in_byte_off = off;
      cycle(name);
   endtask

   task automatic respond(input bit rv, input logic [31:0] w, input string name);
      mem_rvalid = rv; mem_rdata = w;
      cycle(name);
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      model_reset();
      #3;
      checks++;
      if (write_enable !== 0 || write !== 0 || data !== 0 || err !== 0 || in_ready !== 1) begin
         errors++;
         $display("FAIL reset outputs we=%b wr=%0d data=%h err=%b rdy=%b exp 0/0/0/0/1",
                  write_enable, write, data, err, in_ready);
      end
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_alu();
      issue_alu(5'd5, 32'h12345678, 1, "alu_rd5");
      checks++;
      if (write_enable !== 1 || write !== 5'd5 || data !== 32'h12345678) begin
         errors++;
         $display("FAIL alu_direct got %b/%0d/%h exp 1/5/12345678", write_enable, write, data);
      end
      cycle("alu_after");
   endtask

   task automatic test_loads();
      logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      logic [31:0] ws  [5] = '{32'h0080FF11, 32'h0080FF11, 32'h80017FFF, 32'h80017FFF, 32'h80017FFF};
      logic [31:0] exs [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h80017FFF};
      for (int i = 0; i < 5; i++) begin
         q_rs1 = 5'd7;
         issue_load(5'd7, f3s[i], 2'd2, "load_accept");
         for (int k = 0; k < 3; k++) respond(0, 32'h0, "load_wait");
         respond(1, ws[i], "load_resp");
         checks++;
         if (write_enable !== 1 || write !== 5'd7 || data !== exs[i]) begin
            errors++;
            $display("FAIL load_direct f3=%0d got %b/%0d/%h exp 1/7/%h", f3s[i], write_enable, write, data, exs[i]);
         end
         q_rs1 = 0;
         cycle("load_after");
      end
   endtask

   task automatic test_x0();
      issue_alu(5'd0, 32'hDEADBEEF, 1, "alu_rd0");
      checks++;
      if (write_enable !== 0) begin
         errors++;
         $display("FAIL alu_rd0_direct write_enable got %b exp 0", write_enable);
      end
      issue_alu(5'd4, 32'h0000_4444, 0, "alu_nowrite");
      q_rs1 = 0;
      issue_load(5'd0, 3'b010, 2'd0, "load_rd0_accept");
      respond(0, 32'h0, "load_rd0_wait");
      respond(1, 32'hCAFEF00D, "load_rd0_resp");
      respond(1, 32'h1111_2222, "rvalid_in_idle");
   endtask

   task automatic test_back_to_back();
      issue_alu(5'd1, 32'h0000_0001, 1, "b2b_rd1");
      issue_alu(5'd2, 32'h0000_0002, 1, "b2b_rd2");
      q_rs2 = 5'd2;
      issue_alu(5'd3, 32'h0000_0003, 1, "b2b_rd3");
      q_rs2 = 0;
      cycle("b2b_tail");
      // Load retires and a new instruction is accepted in the same cycle it writes
      issue_load(5'd12, 3'b001, 2'd0, "b2b_load");
      respond(1, 32'h0000_8123, "b2b_resp");
      issue_alu(5'd13, 32'h0000_0D0D, 1, "b2b_after_load");
      cycle("b2b_end");
   endtask

   task automatic test_timeout();
`ifdef WB_TIMEOUT_EN
      issue_load(5'd20, 3'b010, 2'd0, "to_win_accept");
      for (int k = 0; k < TO - 1; k++) respond(0, 32'h0, "to_win_wait");
      respond(1, 32'h5A5A_5A5A, "to_win_resp");
      issue_load(5'd21, 3'b010, 2'd0, "to_accept");
      q_rs1 = 5'd21;
      for (int k = 0; k < TO; k++) respond(0, 32'h0, "to_wait");
      q_rs1 = 0;
      checks++;
      if (err !== 1 || in_ready !== 1) begin
         errors++;
         $display("FAIL timeout_direct err/in_ready got %b/%b exp 1/1", err, in_ready);
      end
      respond(1, 32'h7777_7777, "to_late_rvalid");
      cycle("to_idle");
`else
      issue_load(5'd22, 3'b000, 2'd3, "nto_accept");
      for (int k = 0; k < 20; k++) respond(0, 32'h0, "nto_wait");
      respond(1, 32'h8000_0000, "nto_resp");
      checks++;
      if (data !== 32'hFFFFFF80 || err !== 0) begin
         errors++;
         $display("FAIL nto_direct data/err got %h/%b exp ffffff80/0", data, err);
      end
`endif
   endtask

   task automatic test_reset_midload();
      issue_alu(5'd9, 32'hA5A5_A5A5, 1, "rst_pre_alu");
      issue_load(5'd9, 3'b010, 2'd0, "rst_load");
      respond(0, 32'h0, "rst_wait");
      q_rs1 = 5'd9;
      #2;
      rst_n = 0;
      #1;
      model_reset();
      checks++;
      if (write_enable !== 0 || write !== 0 || data !== 0 || err !== 0 || in_ready !== 1 || hazard !== 0) begin
         errors++;
         $display("FAIL reset_midload got we=%b wr=%0d data=%h err=%b rdy=%b hz=%b exp 0/0/0/0/1/0",
                  write_enable, write, data, err, in_ready, hazard);
      end
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      respond(1, 32'hFFFF_FFFF, "rst_stale_rvalid");
      q_rs1 = 0;
      cycle("rst_after");
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid      = ($urandom_range(3) != 0);
         in_is_load    = ($urandom_range(2) == 0);
         in_reg_write  = ($urandom_range(7) != 0);
         in_rd         = 5'($urandom_range(31));
         in_funct3     = 3'($urandom_range(7));
         in_byte_off   = 2'($urandom_range(3));
         in_alu_result = $urandom;
         mem_rvalid    = m_busy ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
         mem_rdata     = $urandom;
         q_rs1         = ($urandom_range(1) == 1) ? m_prd : 5'($urandom_range(31));
         q_rs2         = ($urandom_range(1) == 1) ? m_wr  : 5'($urandom_range(31));
         cycle("random");
      end
      clear_inputs();
      // Drain any load left parked by the random sequence
      if (m_busy) respond(1, 32'h0BAD_F00D, "random_drain");
   endtask

   initial begin
      test_reset();
      test_alu();
      test_loads();
      test_x0();
      test_back_to_back();
      test_timeout();
      test_reset_midload();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
